div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Multi-cycle 32-bit integer divider for the execute stage of the 5-stage MIPS pipeline.
//   - Consumes execute-stage DIV/DIVU decode from the controller and both register operands.
//   - Produces quotient (LO) and remainder (HI) for the HI/LO register write path.
//   - Drives a stall request into the hazard unit, which holds stallE while the divide runs.
// PARAMETERS
//   WIDTH   32   operand/result width; the iteration counter is clog2(WIDTH) bits
// PORTS
//   clk        in   1      pipeline clock; all state updates on rising edge
//   rst        in   1      synchronous, active-low reset
//   start      in   1      DIV/DIVU present in E stage; held high while stalled
//   signed_op  in   1      1 = DIV (signed), 0 = DIVU; sampled with start in IDLE
//   annul      in   1      cancel: E-stage flush or exception; overrides start
//   a          in   WIDTH  dividend (rs)
//   b          in   WIDTH  divisor (rt)
//   stall_div  out  1      request pipeline stall; to hazard unit
//   ready      out  1      one-cycle pulse, hi/lo valid this cycle
//   lo         out  WIDTH  quotient
//   hi         out  WIDTH  remainder
// BEHAVIOUR
//   - Reset (rst==0 at edge): state=IDLE, count=0, ready=0, lo=0, hi=0. This also applies mid-operation.
//   - States and transitions:
//     - IDLE -> BUSY on start & ~annul. Latch |a| and |b| (magnitudes when signed_op), the sign flags, and count=0.
//     - BUSY: one restoring step per cycle. After WIDTH steps (count==WIDTH-1), go to DONE.
//     - DONE: lasts exactly 1 cycle. ready=1, lo/hi registered valid. Always returns to IDLE.
//   - stall_div = start & ~annul & (state!=DONE). This is combinational, so the pipeline stalls
//     in the start cycle itself.
//   - Latency: start in IDLE at cycle 0; ready in cycle WIDTH+1 (33 for WIDTH=32).
//     This gives WIDTH+1 stall cycles.
//   - Back-to-back divides: in DONE stall is low, so the pipeline advances. A start seen in the
//     following IDLE cycle is a new instruction and is accepted with no dead cycle.
//   - start in BUSY or DONE is ignored; operands are not re-sampled.
//   - Signed fix-up (applied when entering DONE):
//     - quotient is negated if sign(a)!=sign(b);
//     - remainder takes the sign of a.
//   - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0 (wraps, no trap).
//   - annul is synchronous and acts in any state: next state IDLE, ready=0, hi/lo keep their
//     previous values. annul has priority over start in the same cycle.
//   - lo/hi change only on entry to DONE (or reset). They hold at all other times.
// CONFIGURATION
//   - Macro DIV_ZERO_FAST_EN is optional.
//   - Defined: b==0 at start takes IDLE->DONE directly. ready comes in cycle 1, with 1 stall cycle.
//     Results are lo=32'hFFFF_FFFF, hi=a (raw, no sign fix-up), for both DIV and DIVU.
//   - Undefined: b==0 runs the full WIDTH+1 latency. lo/hi contents are UNPREDICTABLE per the
//     architecture, but timing and ready are as normal.
// STRUCTURE
//   - Shared header div_defs.h, included alongside defines.h:
//     - state encodings DIV_IDLE/DIV_BUSY/DIV_DONE (2 bits);
//     - `DIV_WIDTH 32;
//     - alucontrol codes for DIV/DIVU, used by the E-stage decode that drives start/signed_op.
//   - Sub-module div_step (combinational):
//     - inputs: partial remainder, quotient, divisor;
//     - outputs: the shifted/subtracted remainder and the next quotient bit.
//     - Instantiated once; the top holds the FSM, counter and fix-up.
// TESTING
//   1. DIVU a=100, b=7 -> stall_div high cycles 0..32; ready in cycle 33; lo=14, hi=2.
//   2. DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      Also DIV a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
//   3. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, ready at cycle 33.
//   4. Start 100/7, then annul at BUSY cycle 10 -> IDLE next cycle, no ready pulse, lo/hi keep
//      the prior result. A fresh start then completes normally.
//   5. Two DIVU back-to-back (15/4, then 9/3 started the cycle after ready) -> lo/hi=3/3, then
//      3/0. Second ready lands exactly 34 cycles after the first.
//   6. rst low at BUSY cycle 5 -> next cycle state IDLE, lo=hi=0, ready=0, stall_div follows start.
//      With DIV_ZERO_FAST_EN, b=0, a=0x1234 -> ready cycle 1, lo=0xFFFFFFFF, hi=0x1234.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM encodings, default width,
// DIV/DIVU alucontrol codes and the sign fix-up record.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // alucontrol values the E-stage decode turns into start/signed_op
  localparam logic [3:0] ALU_DIV  = 4'b1100;
  localparam logic [3:0] ALU_DIVU = 4'b1101;

  typedef struct packed {
    logic neg_quo;
    logic neg_rem;
  } div_sign_t;

  function automatic logic is_div_op(input logic [3:0] alucontrol);
    return (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Pipeline <-> divider handshake: operands and controls in, stall/ready/results out.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall_div;
  logic             ready;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, signed_op, annul, a, b,
    input  stall_div, ready, lo, hi
  );

  modport slave (
    input  start, signed_op, annul, a, b,
    output stall_div, ready, lo, hi
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           quo_bit;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_i};
  assign quo_bit = ~diff[WIDTH];

  // quo_i doubles as the dividend shift register; the new quotient bit enters at the LSB
  assign rem_o = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], quo_bit};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) with HI/LO results and a pipeline stall request.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero finishes in one cycle with lo=all-ones, hi=a.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  div_sign_t        sign_q, sign_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             accept;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign accept        = bus.start & ~bus.annul;
  assign bus.stall_div = accept & (state_q != DIV_DONE);
  assign bus.ready     = (state_q == DIV_DONE);
  assign bus.lo        = lo_q;
  assign bus.hi        = hi_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    sign_d  = sign_q;

    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          state_d        = DIV_BUSY;
          count_d        = '0;
          rem_d          = '0;
          quo_d          = (bus.signed_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
          dvs_d          = (bus.signed_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
          sign_d.neg_quo = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          sign_d.neg_rem = bus.signed_op & bus.a[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
          if (bus.b == '0) begin
            state_d = DIV_DONE;
            lo_d    = '1;
            hi_d    = bus.a;
          end
`endif
        end
      end
      DIV_BUSY: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        // Final step: results and sign fix-up are captured on the way into DONE
        if (count_q == LAST) begin
          state_d = DIV_DONE;
          lo_d    = sign_q.neg_quo ? -step_quo : step_quo;
          hi_d    = sign_q.neg_rem ? -step_rem : step_rem;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    if (bus.annul) begin
      state_d = DIV_IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      sign_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sign_q  <= sign_d;
    end
  end
endmodule
